// File: rtl/fifo_pkg.sv
// Shared definitions for the 19-bit line format and the wide-word packers.
package fifo_pkg;

    localparam int F19_SOF = 16;
    localparam int F19_EOF = 17;
    localparam int F19_OCC = 18;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // A result of zero marks a completely full word.
    function automatic int wide_occ(input int bytes, input int ratio);
        return bytes % (2 * ratio);
    endfunction

endpackage

// File: rtl/fifo_pipe_reg.sv
// Single-entry holding register with a src/dst ready handshake on both sides.
module fifo_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_src_rdy,
    output logic             in_dst_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src_rdy,
    input  logic             out_dst_rdy
);

    logic vld;

    // Accept a new entry whenever the held one is empty or leaving this cycle.
    assign in_dst_rdy  = !vld | out_dst_rdy;
    assign out_src_rdy = vld;

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            vld      <= 1'b0;
            out_data <= '0;
        end else if (in_src_rdy & in_dst_rdy) begin
            vld      <= 1'b1;
            out_data <= in_data;
        end else if (out_dst_rdy) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo19_to_fifo_wide.sv
// Packs 19-bit lines into RATIO*16-bit words with byte occupancy, zero-filled
// partial words and force-flush of packets truncated by an early sof.
module fifo19_to_fifo_wide
    import fifo_pkg::*;
#(
    parameter int RATIO = 2,
    parameter int LE    = 0,
    parameter int OCCW  = clog2(2 * RATIO)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [18:0]                 i_data,
    input  logic                        i_src_rdy,
    output logic                        i_dst_rdy,
    output logic [RATIO*16+2+OCCW-1:0]  o_data,
    output logic                        o_src_rdy,
    input  logic                        o_dst_rdy,
    output logic                        pkt_err,
    output logic [31:0]                 debug
);

    localparam int IDXW = clog2(RATIO);
    localparam int WW   = RATIO * 16 + 2 + OCCW;
    localparam logic [IDXW-1:0] LAST = IDXW'(RATIO - 1);

    logic [15:0]     lanes [RATIO];
    logic [IDXW-1:0] idx;
    logic            acc_sof;
    logic            acc_eof;
    logic            acc_done;
    logic [OCCW-1:0] acc_occ;

    logic            out_vld;
    logic            pipe_ready;
    logic            load_out;
    logic            trunc;
    logic            in_xfer;
    logic            in_sof;
    logic            in_eof;
    logic            in_occ;
    logic [OCCW-1:0] eof_occ;
    logic [OCCW-1:0] trunc_occ;
    logic [WW-1:0]   acc_word;

    assign in_sof = i_data[F19_SOF];
    assign in_eof = i_data[F19_EOF];
    assign in_occ = i_data[F19_OCC];

    assign load_out  = acc_done & pipe_ready;
    assign trunc     = i_src_rdy & in_sof & (idx != '0) & !acc_done;
    assign i_dst_rdy = (!acc_done | load_out) & !trunc;
    assign in_xfer   = i_src_rdy & i_dst_rdy;

    assign eof_occ   = OCCW'(wide_occ(2 * (int'(idx) + 1) - int'(in_occ), RATIO));
    assign trunc_occ = OCCW'(wide_occ(2 * int'(idx), RATIO));

    // Lane 0 lands in the top 16 bits for big-endian, the bottom for little-endian.
    always_comb begin
        acc_word                   = '0;
        acc_word[WW-1 -: OCCW]     = acc_occ;
        acc_word[RATIO*16+1]       = acc_eof;
        acc_word[RATIO*16]         = acc_sof;
        for (int i = 0; i < RATIO; i++) begin
            if (LE != 0) begin
                acc_word[i*16 +: 16] = lanes[i];
            end else begin
                acc_word[(RATIO-1-i)*16 +: 16] = lanes[i];
            end
        end
    end

    // Draining the accumulator zeroes every lane; a line accepted in the same
    // cycle then overwrites lane 0 because the later assignment wins.
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            idx      <= '0;
            acc_sof  <= 1'b0;
            acc_eof  <= 1'b0;
            acc_occ  <= '0;
            acc_done <= 1'b0;
            pkt_err  <= 1'b0;
            for (int i = 0; i < RATIO; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            pkt_err <= trunc;
            if (load_out) begin
                acc_done <= 1'b0;
                acc_sof  <= 1'b0;
                acc_eof  <= 1'b0;
                acc_occ  <= '0;
                for (int i = 0; i < RATIO; i++) begin
                    lanes[i] <= '0;
                end
            end
            if (trunc) begin
                acc_done <= 1'b1;
                acc_eof  <= 1'b1;
                acc_occ  <= trunc_occ;
                idx      <= '0;
            end else if (in_xfer) begin
                lanes[idx] <= i_data[15:0];
                if (idx == '0) begin
                    acc_sof <= in_sof;
                end
                if (in_eof | (idx == LAST)) begin
                    acc_done <= 1'b1;
                    idx      <= '0;
                    acc_eof  <= in_eof;
                    acc_occ  <= in_eof ? eof_occ : '0;
                end else begin
                    idx <= idx + IDXW'(1);
                end
            end
        end
    end

    fifo_pipe_reg #(
        .WIDTH(WW)
    ) out_reg (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_data     (acc_word),
        .in_src_rdy  (acc_done),
        .in_dst_rdy  (pipe_ready),
        .out_data    (o_data),
        .out_src_rdy (out_vld),
        .out_dst_rdy (o_dst_rdy)
    );

    assign o_src_rdy = out_vld;
    assign debug     = {{(30 - IDXW){1'b0}}, out_vld, acc_done, idx};

endmodule

// File: tb/tb_fifo19_to_fifo_wide.sv
// Scoreboard bench for three packer configurations: 2/BE, 4/LE and 8/BE.
module tb_fifo19_to_fifo_wide;

    typedef struct packed {
        logic [1:0]   inst;
        logic [127:0] data;
        logic         sof;
        logic         eof;
        logic [3:0]   occ;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         clr   [3];
    logic [18:0]  idat  [3];
    logic         isrc  [3];
    logic         idst  [3];
    logic         osrc  [3];
    logic         odst  [3];
    logic         perr  [3];
    logic [127:0] w_data[3];
    logic         w_sof [3];
    logic         w_eof [3];
    logic [3:0]   w_occ [3];
    logic [31:0]  w_dbg [3];

    int    total = 0;
    int    bad = 0;
    word_t expq[$];
    int    err_seen[3] = '{0, 0, 0};
    int    exp_err[3]  = '{0, 0, 0};
    logic  rand_mode = 1'b0;
    logic  hold_val = 1'b1;

    logic [15:0] m_lane [3][8];
    int          m_idx[3] = '{0, 0, 0};
    logic        m_sof[3] = '{1'b0, 1'b0, 1'b0};

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int R  = (g == 0) ? 2 : ((g == 1) ? 4 : 8);
        localparam int OW = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
        logic [R*16+2+OW-1:0] od;

        fifo19_to_fifo_wide #(
            .RATIO(R),
            .LE((g == 1) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .clear     (clr[g]),
            .i_data    (idat[g]),
            .i_src_rdy (isrc[g]),
            .i_dst_rdy (idst[g]),
            .o_data    (od),
            .o_src_rdy (osrc[g]),
            .o_dst_rdy (odst[g]),
            .pkt_err   (perr[g]),
            .debug     (w_dbg[g])
        );

        assign w_data[g] = 128'(od[R*16-1:0]);
        assign w_sof[g]  = od[R*16];
        assign w_eof[g]  = od[R*16+1];
        assign w_occ[g]  = 4'(od[R*16+2 +: OW]);
    end

    function automatic word_t mk(input int g, input logic [127:0] d, input logic s,
                                 input logic e, input int o);
        word_t w;
        w.inst = 2'(g);
        w.data = d;
        w.sof  = s;
        w.eof  = e;
        w.occ  = 4'(o);
        return w;
    endfunction

    function automatic int ratio_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 4 : 8);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference packer for random traffic, emitting finished words to the scoreboard.
    task automatic model_emit(input int g, input logic eof, input int bytes);
        int           r;
        logic [127:0] d;
        r = ratio_of(g);
        d = '0;
        for (int i = 0; i < r; i++) begin
            if (g == 1) d[i*16 +: 16] = m_lane[g][i];
            else        d[(r-1-i)*16 +: 16] = m_lane[g][i];
            m_lane[g][i] = '0;
        end
        expq.push_back(mk(g, d, m_sof[g], eof, eof ? (bytes % (2 * r)) : 0));
        m_idx[g] = 0;
        m_sof[g] = 1'b0;
    endtask

    task automatic model_line(input int g, input logic [18:0] line);
        if (line[16] && m_idx[g] != 0) begin
            exp_err[g]++;
            model_emit(g, 1'b1, 2 * m_idx[g]);
        end
        if (m_idx[g] == 0) m_sof[g] = line[16];
        m_lane[g][m_idx[g]] = line[15:0];
        m_idx[g]++;
        if (line[17] || m_idx[g] == ratio_of(g))
            model_emit(g, line[17], 2 * m_idx[g] - (line[17] ? int'(line[18]) : 0));
    endtask

    task automatic applyStimulus(input int g, input logic [18:0] line, input int gap);
        int waited;
        isrc[g] = 1'b0;
        repeat (gap) @(negedge clk);
        idat[g] = line;
        isrc[g] = 1'b1;
        #1;
        waited = 0;
        while (idst[g] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (idst[g] !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout inst=%0d got i_dst_rdy=%b want 1", g, idst[g]);
        end
        @(negedge clk);
        isrc[g] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s drain: got %0d words pending want 0", name, expq.size());
            expq.delete();
        end
    endtask

    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 3; g++) begin
            odst[g] = rand_mode ? ($urandom_range(0, 3) != 0) : hold_val;
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks stall stability.
    word_t prev_word [3];
    logic  prev_stall[3] = '{1'b0, 1'b0, 1'b0};
    always @(negedge clk) begin
        #2;
        for (int g = 0; g < 3; g++) begin
            word_t cur;
            word_t e;
            cur = mk(g, w_data[g], w_sof[g], w_eof[g], int'(w_occ[g]));
            if (perr[g] === 1'b1) err_seen[g]++;
            if (osrc[g] === 1'b1) begin
                if (prev_stall[g]) checkOutput("stall_hold", cur.data, prev_word[g].data);
                if (odst[g] === 1'b1) begin
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_word inst=%0d got data=%0h want none", g, cur.data);
                    end else begin
                        e = expq.pop_front();
                        if (cur !== e) begin
                            bad++;
                            $display("[TB] FAIL word inst=%0d got data=%0h sof=%b eof=%b occ=%0d want inst=%0d data=%0h sof=%b eof=%b occ=%0d",
                                     g, cur.data, cur.sof, cur.eof, cur.occ, e.inst, e.data, e.sof, e.eof, e.occ);
                        end
                    end
                end
                prev_stall[g] = (odst[g] !== 1'b1);
                prev_word[g]  = cur;
            end else begin
                prev_stall[g] = 1'b0;
            end
        end
    end

    logic [18:0] stall_lines [6];

    initial begin
        int k;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            clr[g]  = 1'b0;
            isrc[g] = 1'b0;
            idat[g] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput("rst_o_src_rdy", 128'(osrc[g]), 128'(0));
            checkOutput("rst_i_dst_rdy", 128'(idst[g]), 128'(1));
            checkOutput("rst_pkt_err", 128'(perr[g]), 128'(0));
            checkOutput("rst_o_data", w_data[g], 128'(0));
            checkOutput("rst_debug", 128'(w_dbg[g]), 128'(0));
        end
        @(negedge clk);

        $display("[TB] ratio 2 big-endian packet");
        expq.push_back(mk(0, 128'h1111_2222, 1'b1, 1'b0, 0));
        expq.push_back(mk(0, 128'h3333_4444, 1'b0, 1'b1, 0));
        applyStimulus(0, {3'b001, 16'h1111}, 0);
        applyStimulus(0, {3'b000, 16'h2222}, 0);
        applyStimulus(0, {3'b000, 16'h3333}, 0);
        applyStimulus(0, {3'b010, 16'h4444}, 0);
        wait_drain("t_ratio2");

        $display("[TB] ratio 4 little-endian partial word");
        expq.push_back(mk(1, 128'h0000_CCCC_BBBB_AAAA, 1'b1, 1'b1, 5));
        applyStimulus(1, {3'b001, 16'hAAAA}, 0);
        applyStimulus(1, {3'b000, 16'hBBBB}, 0);
        applyStimulus(1, {3'b110, 16'hCCCC}, 0);
        wait_drain("t_ratio4");

        $display("[TB] ratio 4 truncated packet");
        expq.push_back(mk(1, 128'h0000_0000_5678_1234, 1'b1, 1'b1, 4));
        expq.push_back(mk(1, 128'h0000_0000_DEF0_9ABC, 1'b1, 1'b1, 4));
        exp_err[1]++;
        applyStimulus(1, {3'b001, 16'h1234}, 0);
        applyStimulus(1, {3'b000, 16'h5678}, 0);
        applyStimulus(1, {3'b001, 16'h9ABC}, 0);
        applyStimulus(1, {3'b010, 16'hDEF0}, 0);
        wait_drain("t_trunc");
        checkOutput("trunc_err_pulses", 128'(err_seen[1]), 128'(1));

        $display("[TB] ratio 8 single line and full word");
        expq.push_back(mk(2, 128'hD00D_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b1, 1));
        applyStimulus(2, {3'b111, 16'hD00D}, 0);
        expq.push_back(mk(2, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 1'b1, 1'b1, 0));
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(2, {1'b0, i == 8, i == 1, 16'(i)}, 0);
        end
        wait_drain("t_ratio8");

        $display("[TB] ratio 2 output stall");
        for (int i = 0; i < 6; i++) begin
            stall_lines[i] = {1'b0, i == 5, i == 0, 16'hA001 + 16'(i)};
        end
        expq.push_back(mk(0, 128'hA001_A002, 1'b1, 1'b0, 0));
        expq.push_back(mk(0, 128'hA003_A004, 1'b0, 1'b0, 0));
        expq.push_back(mk(0, 128'hA005_A006, 1'b0, 1'b1, 0));
        hold_val = 1'b0;
        repeat (2) @(negedge clk);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            idat[0] = stall_lines[k];
            isrc[0] = 1'b1;
            #1;
            if (idst[0] === 1'b1 && k < 5) k++;
            @(negedge clk);
        end
        #1;
        checkOutput("stall_accepted", 128'(k), 128'(4));
        checkOutput("stall_i_dst_rdy", 128'(idst[0]), 128'(0));
        @(negedge clk);
        isrc[0]  = 1'b0;
        hold_val = 1'b1;
        for (int i = k; i < 6; i++) begin
            applyStimulus(0, stall_lines[i], 0);
        end
        wait_drain("t_stall");

        $display("[TB] reset mid-packet");
        applyStimulus(0, {3'b001, 16'hB001}, 0);
        #1;
        checkOutput("mid_debug_idx", 128'(w_dbg[0]), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_o_src_rdy", 128'(osrc[0]), 128'(0));
        checkOutput("mid_rst_pkt_err", 128'(perr[0]), 128'(0));
        checkOutput("mid_rst_debug", 128'(w_dbg[0]), 128'(0));
        @(negedge clk);
        expq.push_back(mk(0, 128'hC001_C002, 1'b1, 1'b1, 3));
        applyStimulus(0, {3'b001, 16'hC001}, 0);
        applyStimulus(0, {3'b110, 16'hC002}, 0);
        wait_drain("t_reset");

        $display("[TB] clear mid-packet");
        applyStimulus(2, {3'b001, 16'hEEEE}, 0);
        #1;
        checkOutput("clr_debug_before", 128'(w_dbg[2]), 128'(1));
        @(negedge clk);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        #1;
        checkOutput("clr_debug_after", 128'(w_dbg[2]), 128'(0));
        checkOutput("clr_o_src_rdy", 128'(osrc[2]), 128'(0));
        @(negedge clk);
        expq.push_back(mk(2, 128'hF001_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b1, 2));
        applyStimulus(2, {3'b011, 16'hF001}, 0);
        wait_drain("t_clear");

        $display("[TB] random traffic");
        rand_mode = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int p = 0; p < 200; p++) begin
                int   len;
                logic noeof;
                len   = $urandom_range(1, 17);
                noeof = (p != 199) && ($urandom_range(0, 9) == 0);
                for (int l = 0; l < len; l++) begin
                    logic [18:0] line;
                    logic        e;
                    e    = (l == len - 1) && !noeof;
                    line = {e ? 1'($urandom_range(0, 1)) : 1'b0, e, l == 0, 16'($urandom)};
                    model_line(g, line);
                    applyStimulus(g, line, ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 2));
                end
            end
            wait_drain("t_random");
        end
        rand_mode = 1'b0;

        for (int g = 0; g < 3; g++) begin
            checkOutput("err_count", 128'(err_seen[g]), 128'(exp_err[g]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no finish want finish before 900000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
